imm_decode_stage: RTL and testbench
===================================

Name: imm_decode_stage

Overview:
- Registered, handshaked immediate-generation stage for the RV32I/RV64I decode path.
- Recognises every base-ISA instruction format (R, I, S, B, U, J) and produces the correctly sign-extended XLEN-wide immediate, a format code and a legality flag.
- Carries a tag through with the result.
- A 2-entry skid buffer decouples fetch from the downstream register-read stage.
- A saturating counter records illegal opcodes for debug.

Parameters:
- XLEN, 32, immediate output width; legal values 32 or 64.
- TAG_W, 8, width of the sideband tag (PC index or ROB id), passed through unchanged.
- ILL_CNT_W, 16, width of the saturating illegal-opcode counter.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous flush; discards all buffered entries
- in_valid  in  1  instruction valid
- in_ready  out  1  stage can accept an instruction
- in_instr  in  32  instruction word
- in_tag  in  TAG_W  sideband tag
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts the result
- out_imm  out  XLEN  sign-extended immediate
- out_fmt  out  3  format code: 0 R, 1 I, 2 S, 3 B, 4 U, 5 J, 7 illegal
- out_illegal  out  1  opcode not recognised
- out_tag  out  TAG_W  tag of the result
- ill_count  out  ILL_CNT_W  saturating count of illegal instructions accepted

Behaviour:
- Reset (rst_n low, asynchronous):
  - out_valid=0, out_imm=0, out_fmt=0, out_illegal=0, out_tag=0, ill_count=0.
  - Both buffer entries are emptied; in_ready=1 on the first edge after release.
- Decode, selected by opcode in_instr[6:0]; all immediates are sign-extended from instr[31] to XLEN:
  - I-type: 0000011, 0010011, 1100111, 0001111, 1110011. imm = instr[31:20].
  - S-type: 0100011. imm = {instr[31:25], instr[11:7]}.
  - B-type: 1100011. imm = {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}.
  - U-type: 0110111, 0010111. imm = {instr[31:12], 12'b0}; for XLEN=64 this value is sign-extended.
  - J-type: 1101111. imm = {instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}.
  - R-type: 0110011. imm = 0, fmt = 0.
  - Any other opcode: imm = 0, fmt = 7, illegal = 1.
- Decode happens combinationally on the input side; the registered result is stored.
- Latency: an instruction accepted at edge N appears on the outputs after edge N (out_valid high in cycle N+1) when the output register is empty or draining.
- Buffer:
  - Output register (OR) plus skid register (SK).
  - in_ready = !SK_full; it is registered and does not depend combinationally on out_ready.
  - Input fire = in_valid & in_ready.
  - Output fire = out_valid & out_ready.
- Update rules at each edge, in priority order:
  1. If OR is empty or out fires: OR loads SK if SK is full (SK empties), else OR loads the input if input fires, else OR goes empty.
  2. If out does not fire and OR is full, input fire loads SK.
  3. If SK is unloaded and refilled in the same cycle, SK takes the new input while OR takes the old SK content.
- Order is strictly FIFO; there is no loss or duplication under any valid/ready pattern.
- out_* fields are held stable while out_valid=1 and out_ready=0.
- Flush:
  - At the next edge, OR and SK are emptied, out_valid=0 and in_ready=1.
  - An input presented in the flush cycle is dropped and not counted.
  - ill_count is not cleared by flush.
- ill_count increments on each input fire with an illegal opcode (when not flushing) and saturates at all-ones.
- Reset asserted mid-transfer discards all entries immediately.

Test Plan:
- Single I-type: XLEN=32, addi 0xFFF00093, out_ready=1 → next cycle out_imm=0xFFFFFFFF, fmt=1, illegal=0, tag echoed.
- S/B/J formats:
  - sw 0xFE112E23 → 0xFFFFFFFC, fmt 2.
  - beq 0xFE000CE3 → 0xFFFFFFF8, fmt 3.
  - jal 0xFFDFF06F → 0xFFFFFFFC, fmt 5.
- U-type width:
  - XLEN=32, lui 0x123452B7 → 0x12345000, fmt 4.
  - XLEN=64, 0x800002B7 → 0xFFFFFFFF80000000.
- Backpressure: tags 1, 2, 3 back-to-back with out_ready=0 → tags 1 and 2 accepted, in_ready low from the cycle after tag 2. Then out_ready=1 → outputs in order 1, 2, 3; no gaps once streaming; in_ready returns high.
- Illegal and saturation: ILL_CNT_W=2, opcode 0x7F sent 5 times → fmt=7, illegal=1, imm=0 each time; ill_count = 1, 2, 3, 3, 3.
- Flush and reset: with both entries full, pulse flush → out_valid=0, in_ready=1 next cycle, ill_count unchanged. Assert rst_n mid-stream → all outputs 0 immediately.

Source files
------------

// File: rtl/imm_decode_stage.sv
// Immediate-generation decode stage: combinational RV32I/RV64I immediate
// decode on the input side, followed by a 2-entry (output + skid) buffer
// with a registered in_ready and a saturating illegal-opcode counter.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high; a producer holding valid keeps its payload stable until ready,
// and this stage holds out_* stable while out_valid=1 and out_ready=0.
module imm_decode_stage #(
  parameter int XLEN      = 32,
  parameter int TAG_W     = 8,
  parameter int ILL_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          in_instr,
  input  logic [TAG_W-1:0]     in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [XLEN-1:0]      out_imm,
  output logic [2:0]           out_fmt,
  output logic                 out_illegal,
  output logic [TAG_W-1:0]     out_tag,
  output logic [ILL_CNT_W-1:0] ill_count
);

  localparam logic [2:0] FMT_R   = 3'd0;
  localparam logic [2:0] FMT_I   = 3'd1;
  localparam logic [2:0] FMT_S   = 3'd2;
  localparam logic [2:0] FMT_B   = 3'd3;
  localparam logic [2:0] FMT_U   = 3'd4;
  localparam logic [2:0] FMT_J   = 3'd5;
  localparam logic [2:0] FMT_ILL = 3'd7;

  // Decoded view of the incoming instruction
  logic [31:0]        imm32;
  logic signed [31:0] imm_s;
  logic [XLEN-1:0]    dec_imm;
  logic [2:0]         dec_fmt;
  logic               dec_ill;

  // Output register (OR) and skid register (SK)
  logic               or_valid, sk_valid;
  logic [XLEN-1:0]    or_imm, sk_imm;
  logic [2:0]         or_fmt, sk_fmt;
  logic               or_ill, sk_ill;
  logic [TAG_W-1:0]   or_tag, sk_tag;
  logic               ready_q;

  // Next-state control
  logic in_fire, out_fire, or_take;
  logic or_valid_n, sk_valid_n;
  logic ld_or_sk, ld_or_in, ld_sk;

  // Opcode-driven immediate assembly; every immediate is sign-extended from bit 31
  always_comb begin
    imm32   = '0;
    dec_fmt = FMT_R;
    dec_ill = 1'b0;
    case (in_instr[6:0])
      7'b0000011, 7'b0010011, 7'b1100111, 7'b0001111, 7'b1110011: begin
        imm32   = {{20{in_instr[31]}}, in_instr[31:20]};
        dec_fmt = FMT_I;
      end
      7'b0100011: begin
        imm32   = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
        dec_fmt = FMT_S;
      end
      7'b1100011: begin
        imm32   = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                   in_instr[30:25], in_instr[11:8], 1'b0};
        dec_fmt = FMT_B;
      end
      7'b0110111, 7'b0010111: begin
        imm32   = {in_instr[31:12], 12'b0};
        dec_fmt = FMT_U;
      end
      7'b1101111: begin
        imm32   = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                   in_instr[20], in_instr[30:21], 1'b0};
        dec_fmt = FMT_J;
      end
      7'b0110011: begin
        imm32   = '0;
        dec_fmt = FMT_R;
      end
      default: begin
        imm32   = '0;
        dec_fmt = FMT_ILL;
        dec_ill = 1'b1;
      end
    endcase
  end

  // Widening a signed value sign-extends it for XLEN=64 (identity for 32)
  assign imm_s   = imm32;
  assign dec_imm = XLEN'(imm_s);

  assign in_ready    = ready_q;
  assign in_fire     = in_valid & ready_q;
  assign out_fire    = or_valid & out_ready;
  assign out_valid   = or_valid;
  assign out_imm     = or_imm;
  assign out_fmt     = or_fmt;
  assign out_illegal = or_ill;
  assign out_tag     = or_tag;

  // Buffer steering: OR refills from SK first to keep FIFO order
  always_comb begin
    or_take    = !or_valid || out_fire;
    or_valid_n = or_valid;
    sk_valid_n = sk_valid;
    ld_or_sk   = 1'b0;
    ld_or_in   = 1'b0;
    ld_sk      = 1'b0;
    if (flush) begin
      or_valid_n = 1'b0;
      sk_valid_n = 1'b0;
    end else if (or_take) begin
      if (sk_valid) begin
        ld_or_sk   = 1'b1;
        or_valid_n = 1'b1;
        sk_valid_n = in_fire;
        ld_sk      = in_fire;
      end else if (in_fire) begin
        ld_or_in   = 1'b1;
        or_valid_n = 1'b1;
      end else begin
        or_valid_n = 1'b0;
      end
    end else if (in_fire) begin
      ld_sk      = 1'b1;
      sk_valid_n = 1'b1;
    end
  end

  // Occupancy flags and the registered ready (ready only when SK will be free)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      or_valid <= 1'b0;
      sk_valid <= 1'b0;
      ready_q  <= 1'b0;
    end else begin
      or_valid <= or_valid_n;
      sk_valid <= sk_valid_n;
      ready_q  <= !sk_valid_n;
    end
  end

  // Payload registers; untouched unless loaded so a stalled output stays stable
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      or_imm <= '0;
      or_fmt <= '0;
      or_ill <= 1'b0;
      or_tag <= '0;
      sk_imm <= '0;
      sk_fmt <= '0;
      sk_ill <= 1'b0;
      sk_tag <= '0;
    end else begin
      if (ld_or_sk) begin
        or_imm <= sk_imm;
        or_fmt <= sk_fmt;
        or_ill <= sk_ill;
        or_tag <= sk_tag;
      end else if (ld_or_in) begin
        or_imm <= dec_imm;
        or_fmt <= dec_fmt;
        or_ill <= dec_ill;
        or_tag <= in_tag;
      end
      if (ld_sk) begin
        sk_imm <= dec_imm;
        sk_fmt <= dec_fmt;
        sk_ill <= dec_ill;
        sk_tag <= in_tag;
      end
    end
  end

  // Saturating count of accepted illegal instructions; survives flush
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ill_count <= '0;
    end else if (in_fire && dec_ill && !flush && (ill_count != '1)) begin
      ill_count <= ill_count + ILL_CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_imm_decode_stage.sv
// Bench for imm_decode_stage: a 32-bit instance (16-bit counter) and a
// 64-bit instance (2-bit counter) driven by the same stimulus and checked
// against an arithmetic immediate model and an expected-result queue.
module tb_imm_decode_stage;

  typedef struct packed {
    logic [63:0] imm;
    logic [2:0]  fmt;
    logic        ill;
    logic [7:0]  tag;
  } exp_t;

  logic        clk, rst_n, flush, in_valid, out_ready;
  logic [31:0] in_instr;
  logic [7:0]  in_tag;
  logic        in_ready_a, out_valid_a, out_illegal_a;
  logic        in_ready_b, out_valid_b, out_illegal_b;
  logic [31:0] out_imm_a;
  logic [63:0] out_imm_b;
  logic [2:0]  out_fmt_a, out_fmt_b;
  logic [7:0]  out_tag_a, out_tag_b;
  logic [15:0] ill_count_a;
  logic [1:0]  ill_count_b;

  int   checks = 0;
  int   errors = 0;
  int   ill_exp_a = 0;
  int   ill_exp_b = 0;
  exp_t exp_q[$];

  imm_decode_stage #(.XLEN(32), .TAG_W(8), .ILL_CNT_W(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready_a), .in_instr(in_instr), .in_tag(in_tag),
    .out_valid(out_valid_a), .out_ready(out_ready), .out_imm(out_imm_a),
    .out_fmt(out_fmt_a), .out_illegal(out_illegal_a), .out_tag(out_tag_a),
    .ill_count(ill_count_a)
  );

  imm_decode_stage #(.XLEN(64), .TAG_W(8), .ILL_CNT_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready_b), .in_instr(in_instr), .in_tag(in_tag),
    .out_valid(out_valid_b), .out_ready(out_ready), .out_imm(out_imm_b),
    .out_fmt(out_fmt_b), .out_illegal(out_illegal_b), .out_tag(out_tag_b),
    .ill_count(ill_count_b)
  );

  // clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference: immediate value as a signed integer built from the field weights
  function automatic exp_t ref_decode(input logic [31:0] i, input logic [7:0] tag);
    longint v;
    exp_t   e;
    v = 0;
    e.fmt = 3'd0;
    e.ill = 1'b0;
    case (i[6:0])
      7'h03, 7'h13, 7'h67, 7'h0F, 7'h73: begin
        v = longint'(i[31:20]);
        if (v >= 2048) v = v - 4096;
        e.fmt = 3'd1;
      end
      7'h23: begin
        v = longint'(i[31:25]) * 32 + longint'(i[11:7]);
        if (v >= 2048) v = v - 4096;
        e.fmt = 3'd2;
      end
      7'h63: begin
        v = longint'(i[31]) * 4096 + longint'(i[7]) * 2048 +
            longint'(i[30:25]) * 32 + longint'(i[11:8]) * 2;
        if (v >= 4096) v = v - 8192;
        e.fmt = 3'd3;
      end
      7'h37, 7'h17: begin
        v = longint'(i[31:12]) * 4096;
        if (i[31]) v = v - 64'sh1_0000_0000;
        e.fmt = 3'd4;
      end
      7'h6F: begin
        v = longint'(i[31]) * 1048576 + longint'(i[19:12]) * 4096 +
            longint'(i[20]) * 2048 + longint'(i[30:21]) * 2;
        if (v >= 1048576) v = v - 2097152;
        e.fmt = 3'd5;
      end
      7'h33: e.fmt = 3'd0;
      default: begin
        e.fmt = 3'd7;
        e.ill = 1'b1;
      end
    endcase
    e.imm = v;
    e.tag = tag;
    return e;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [6:0] ops [12];
    logic [31:0] r;
    ops = '{7'h03, 7'h13, 7'h67, 7'h0F, 7'h73, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33, 7'h7F};
    r = $urandom;
    if ($urandom_range(0, 7) == 0) return r;
    return {r[31:7], ops[$urandom_range(0, 11)]};
  endfunction

  task automatic count_illegal(input exp_t e);
    if (e.ill) begin
      ill_exp_a = ill_exp_a + 1;
      if (ill_exp_b < 3) ill_exp_b = ill_exp_b + 1;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_instr = '0; in_tag = '0;
    #12;
    checks++;
    if ({out_valid_a, out_imm_a, out_fmt_a, out_illegal_a, out_tag_a, ill_count_a} !== '0) begin
      errors++;
      $display("FAIL reset_a: valid=%0b imm=%h fmt=%0d ill=%0b tag=%h cnt=%0d, want all 0",
               out_valid_a, out_imm_a, out_fmt_a, out_illegal_a, out_tag_a, ill_count_a);
    end
    checks++;
    if ({out_valid_b, out_imm_b, out_fmt_b, out_illegal_b, out_tag_b, ill_count_b} !== '0) begin
      errors++;
      $display("FAIL reset_b: valid=%0b imm=%h fmt=%0d ill=%0b tag=%h cnt=%0d, want all 0",
               out_valid_b, out_imm_b, out_fmt_b, out_illegal_b, out_tag_b, ill_count_b);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    checks++;
    if (in_ready_a !== 1'b1 || in_ready_b !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: in_ready a=%0b b=%0b, want 1", in_ready_a, in_ready_b);
    end
  endtask

  task automatic test_formats();
    logic [31:0] vec_i [6];
    logic [31:0] vec_a [6];
    logic [63:0] vec_b [6];
    logic [2:0]  vec_f [6];
    vec_i = '{32'hFFF00093, 32'hFE112E23, 32'hFE000CE3, 32'hFFDFF06F, 32'h123452B7, 32'h800002B7};
    vec_a = '{32'hFFFFFFFF, 32'hFFFFFFFC, 32'hFFFFFFF8, 32'hFFFFFFFC, 32'h12345000, 32'h80000000};
    vec_b = '{64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFC, 64'hFFFFFFFFFFFFFFF8,
              64'hFFFFFFFFFFFFFFFC, 64'h0000000012345000, 64'hFFFFFFFF80000000};
    vec_f = '{3'd1, 3'd2, 3'd3, 3'd5, 3'd4, 3'd4};
    for (int k = 0; k < 6; k++) begin
      in_instr = vec_i[k]; in_tag = 8'(8'h40 + k); in_valid = 1'b1; out_ready = 1'b1;
      checks++;
      if (in_ready_a !== 1'b1) begin
        errors++;
        $display("FAIL fmt_ready[%0d]: in_ready=%0b, want 1", k, in_ready_a);
      end
      tick();
      in_valid = 1'b0;
      checks++;
      if (out_valid_a !== 1'b1 || out_imm_a !== vec_a[k] || out_fmt_a !== vec_f[k] ||
          out_illegal_a !== 1'b0 || out_tag_a !== 8'(8'h40 + k)) begin
        errors++;
        $display("FAIL fmt_a[%0d]: valid=%0b imm=%h fmt=%0d ill=%0b tag=%h, want 1 %h %0d 0 %h",
                 k, out_valid_a, out_imm_a, out_fmt_a, out_illegal_a, out_tag_a,
                 vec_a[k], vec_f[k], 8'(8'h40 + k));
      end
      checks++;
      if (out_valid_b !== 1'b1 || out_imm_b !== vec_b[k] || out_fmt_b !== vec_f[k] ||
          out_tag_b !== 8'(8'h40 + k)) begin
        errors++;
        $display("FAIL fmt_b[%0d]: valid=%0b imm=%h fmt=%0d tag=%h, want 1 %h %0d %h",
                 k, out_valid_b, out_imm_b, out_fmt_b, out_tag_b, vec_b[k], vec_f[k], 8'(8'h40 + k));
      end
    end
    tick();
  endtask

  task automatic test_illegal_saturation();
    logic [31:0] r;
    for (int k = 1; k <= 5; k++) begin
      r = $urandom;
      in_instr = {r[31:7], 7'h7F}; in_tag = 8'(k); in_valid = 1'b1; out_ready = 1'b1;
      ill_exp_a = ill_exp_a + 1;
      if (ill_exp_b < 3) ill_exp_b = ill_exp_b + 1;
      tick();
      in_valid = 1'b0;
      checks++;
      if (out_valid_b !== 1'b1 || out_fmt_b !== 3'd7 || out_illegal_b !== 1'b1 ||
          out_imm_b !== 64'd0 || out_fmt_a !== 3'd7 || out_imm_a !== 32'd0) begin
        errors++;
        $display("FAIL illegal[%0d]: valid=%0b fmt=%0d/%0d ill=%0b imm=%h/%h, want 1 7 1 0",
                 k, out_valid_b, out_fmt_a, out_fmt_b, out_illegal_b, out_imm_a, out_imm_b);
      end
      checks++;
      if (ill_count_b !== 2'(ill_exp_b) || ill_count_a !== 16'(ill_exp_a)) begin
        errors++;
        $display("FAIL ill_count[%0d]: a=%0d b=%0d, want a=%0d b=%0d",
                 k, ill_count_a, ill_count_b, ill_exp_a, ill_exp_b);
      end
    end
    tick();
  endtask

  task automatic test_backpressure();
    in_instr = 32'h00B50533; out_ready = 1'b0; in_valid = 1'b1; in_tag = 8'd1;
    tick();
    in_tag = 8'd2;
    checks++;
    if (out_valid_a !== 1'b1 || out_tag_a !== 8'd1 || in_ready_a !== 1'b1) begin
      errors++;
      $display("FAIL bp_first: valid=%0b tag=%0d ready=%0b, want 1 1 1", out_valid_a, out_tag_a, in_ready_a);
    end
    tick();
    in_tag = 8'd3;
    checks++;
    if (in_ready_a !== 1'b0 || in_ready_b !== 1'b0 || out_tag_a !== 8'd1) begin
      errors++;
      $display("FAIL bp_full: ready=%0b/%0b tag=%0d, want 0 0 1", in_ready_a, in_ready_b, out_tag_a);
    end
    tick();
    checks++;
    if (in_ready_a !== 1'b0 || out_valid_a !== 1'b1 || out_tag_a !== 8'd1) begin
      errors++;
      $display("FAIL bp_hold: ready=%0b valid=%0b tag=%0d, want 0 1 1", in_ready_a, out_valid_a, out_tag_a);
    end
    out_ready = 1'b1;
    tick();
    checks++;
    if (out_valid_a !== 1'b1 || out_tag_a !== 8'd2 || in_ready_a !== 1'b1) begin
      errors++;
      $display("FAIL bp_drain2: valid=%0b tag=%0d ready=%0b, want 1 2 1", out_valid_a, out_tag_a, in_ready_a);
    end
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_valid_a !== 1'b1 || out_tag_a !== 8'd3 || out_tag_b !== 8'd3) begin
      errors++;
      $display("FAIL bp_drain3: valid=%0b tag=%0d/%0d, want 1 3", out_valid_a, out_tag_a, out_tag_b);
    end
    tick();
    checks++;
    if (out_valid_a !== 1'b0 || in_ready_a !== 1'b1) begin
      errors++;
      $display("FAIL bp_empty: valid=%0b ready=%0b, want 0 1", out_valid_a, in_ready_a);
    end
  endtask

  task automatic test_flush();
    in_instr = 32'h00B50533; out_ready = 1'b0; in_valid = 1'b1; in_tag = 8'h10;
    tick();
    in_tag = 8'h11;
    tick();
    in_valid = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checks++;
    if (out_valid_a !== 1'b0 || out_valid_b !== 1'b0 || in_ready_a !== 1'b1 || in_ready_b !== 1'b1) begin
      errors++;
      $display("FAIL flush_full: valid=%0b/%0b ready=%0b/%0b, want 0 1",
               out_valid_a, out_valid_b, in_ready_a, in_ready_b);
    end
    checks++;
    if (ill_count_a !== 16'(ill_exp_a) || ill_count_b !== 2'(ill_exp_b)) begin
      errors++;
      $display("FAIL flush_count: a=%0d b=%0d, want %0d %0d", ill_count_a, ill_count_b, ill_exp_a, ill_exp_b);
    end
    in_valid = 1'b1; in_tag = 8'h20;
    tick();
    in_instr = 32'h0000007F; in_tag = 8'h21; flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    checks++;
    if (out_valid_a !== 1'b0 || ill_count_a !== 16'(ill_exp_a) || ill_count_b !== 2'(ill_exp_b)) begin
      errors++;
      $display("FAIL flush_drop: valid=%0b cnt=%0d/%0d, want 0 %0d %0d",
               out_valid_a, ill_count_a, ill_count_b, ill_exp_a, ill_exp_b);
    end
    tick();
    checks++;
    if (out_valid_a !== 1'b0 || out_valid_b !== 1'b0) begin
      errors++;
      $display("FAIL flush_ghost: valid=%0b/%0b, want 0", out_valid_a, out_valid_b);
    end
  endtask

  task automatic test_random();
    exp_t        e;
    logic        stalled;
    logic [31:0] held_imm;
    logic [7:0]  held_tag;
    logic        fire;
    stalled = 1'b0; held_imm = '0; held_tag = '0;
    exp_q.delete();
    for (int cyc = 0; cyc < 800; cyc++) begin
      in_valid  = (cyc < 770) && ($urandom_range(0, 3) != 0);
      in_instr  = rand_instr();
      in_tag    = 8'($urandom);
      out_ready = (cyc >= 770) || ($urandom_range(0, 2) != 0);
      #1;
      checks++;
      if (out_valid_a !== (exp_q.size() != 0) || out_valid_b !== out_valid_a || in_ready_b !== in_ready_a) begin
        errors++;
        $display("FAIL rnd_valid[%0d]: valid=%0b/%0b ready=%0b/%0b, want valid %0b",
                 cyc, out_valid_a, out_valid_b, in_ready_a, in_ready_b, exp_q.size() != 0);
      end
      if (stalled && out_valid_a) begin
        checks++;
        if (out_imm_a !== held_imm || out_tag_a !== held_tag) begin
          errors++;
          $display("FAIL rnd_stable[%0d]: imm=%h tag=%h, want %h %h", cyc, out_imm_a, out_tag_a, held_imm, held_tag);
        end
      end
      checks++;
      if (ill_count_a !== 16'(ill_exp_a) || ill_count_b !== 2'(ill_exp_b)) begin
        errors++;
        $display("FAIL rnd_count[%0d]: a=%0d b=%0d, want %0d %0d", cyc, ill_count_a, ill_count_b, ill_exp_a, ill_exp_b);
      end
      if (out_valid_a && out_ready && exp_q.size() != 0) begin
        e = exp_q.pop_front();
        checks++;
        if (out_imm_a !== e.imm[31:0] || out_imm_b !== e.imm || out_fmt_a !== e.fmt ||
            out_fmt_b !== e.fmt || out_illegal_a !== e.ill || out_tag_a !== e.tag || out_tag_b !== e.tag) begin
          errors++;
          $display("FAIL rnd_data[%0d]: imm=%h/%h fmt=%0d ill=%0b tag=%h, want %h %0d %0b %h",
                   cyc, out_imm_a, out_imm_b, out_fmt_a, out_illegal_a, out_tag_a, e.imm, e.fmt, e.ill, e.tag);
        end
      end
      fire = in_valid && in_ready_a;
      if (fire) begin
        e = ref_decode(in_instr, in_tag);
        exp_q.push_back(e);
        count_illegal(e);
      end
      stalled  = out_valid_a && !out_ready;
      held_imm = out_imm_a;
      held_tag = out_tag_a;
      tick();
    end
    in_valid = 1'b0;
    checks++;
    if (exp_q.size() != 0 || out_valid_a !== 1'b0) begin
      errors++;
      $display("FAIL rnd_drain: %0d results missing, valid=%0b, want 0 0", exp_q.size(), out_valid_a);
    end
  endtask

  task automatic test_reset_midstream();
    in_instr = 32'hFFF00093; out_ready = 1'b0; in_valid = 1'b1; in_tag = 8'h77;
    tick();
    tick();
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    ill_exp_a = 0;
    ill_exp_b = 0;
    checks++;
    if ({out_valid_a, out_imm_a, out_fmt_a, out_illegal_a, out_tag_a, ill_count_a} !== '0 ||
        {out_valid_b, out_imm_b, out_tag_b, ill_count_b} !== '0) begin
      errors++;
      $display("FAIL midreset: valid=%0b imm=%h fmt=%0d tag=%h cnt=%0d/%0d, want all 0",
               out_valid_a, out_imm_a, out_fmt_a, out_tag_a, ill_count_a, ill_count_b);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    checks++;
    if (out_valid_a !== 1'b0 || in_ready_a !== 1'b1) begin
      errors++;
      $display("FAIL midreset_after: valid=%0b ready=%0b, want 0 1", out_valid_a, in_ready_a);
    end
  endtask

  // watchdog
  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_formats();
    test_illegal_saturation();
    test_backpressure();
    test_flush();
    test_random();
    test_reset_midstream();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
